// File: rtl/bias_relu_quant.sv
// Bias add, optional ReLU, round-half-up requantization and saturation over K lanes,
// as a 2-deep elastic valid/ready pipeline with a saturating clip-event counter.
module bias_relu_quant #(
    parameter int unsigned K_CHANNELS    = 4,
    parameter int unsigned ACC_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned SHIFT_WIDTH   = 5,
    parameter int unsigned SAT_CNT_WIDTH = 16
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic                                   acc_valid_i,
    output logic                                   acc_ready_o,
    input  logic [K_CHANNELS-1:0][ACC_WIDTH-1:0]   acc_data_i,
    input  logic                                   acc_last_i,
    input  logic [K_CHANNELS-1:0][ACC_WIDTH-1:0]   bias_i,
    input  logic [SHIFT_WIDTH-1:0]                 shift_i,
    input  logic                                   relu_en_i,
    output logic                                   out_valid_o,
    input  logic                                   out_ready_i,
    output logic [K_CHANNELS-1:0][DATA_WIDTH-1:0]  out_data_o,
    output logic                                   out_last_o,
    output logic [SAT_CNT_WIDTH-1:0]               sat_cnt_o
);

    localparam int unsigned SUM_W = ACC_WIDTH + 1;
    localparam int unsigned RND_W = ACC_WIDTH + 2;
    localparam int unsigned POP_W = $clog2(K_CHANNELS + 1);

    localparam logic signed [RND_W-1:0] C_QMAX = RND_W'(2 ** (DATA_WIDTH - 1) - 1);
    localparam logic signed [RND_W-1:0] C_QMIN = ~C_QMAX;
    localparam logic signed [RND_W-1:0] C_ONE  = RND_W'(1);

    logic                                  w_s1_adv;
    logic                                  w_in_acc;
    logic                                  w_s2_load;
    logic [K_CHANNELS-1:0][SUM_W-1:0]      w_sum;
    logic [K_CHANNELS-1:0][DATA_WIDTH-1:0] w_q;
    logic [K_CHANNELS-1:0]                 w_sat;
    logic [POP_W-1:0]                      w_sat_pop;
    logic [SAT_CNT_WIDTH:0]                w_sat_sum;

    logic                                  r_s1_valid;
    logic                                  r_s1_last;
    logic                                  r_s1_relu;
    logic [SHIFT_WIDTH-1:0]                r_s1_shift;
    logic [K_CHANNELS-1:0][SUM_W-1:0]      r_s1_sum;
    logic                                  r_s2_valid;
    logic                                  r_out_last;
    logic [K_CHANNELS-1:0][DATA_WIDTH-1:0] r_out_data;
    logic [SAT_CNT_WIDTH-1:0]              r_sat_cnt;

    // Round-half-up as floor((floor(x / 2^(s-1)) + 1) / 2); exact for any shift, no X.
    function automatic logic [DATA_WIDTH:0] f_quant(
        input logic signed [SUM_W-1:0] sum,
        input logic [SHIFT_WIDTH-1:0]  sh,
        input logic                    relu
    );
        logic signed [RND_W-1:0] v_ext;
        logic signed [RND_W-1:0] v_t;
        logic signed [RND_W-1:0] v_r;
        logic                    v_sat;
        v_ext = RND_W'(sum);
        v_t   = '0;
        v_r   = '0;
        v_sat = 1'b0;
        if (!(relu && sum[SUM_W-1])) begin
            if (sh == '0) begin
                v_r = v_ext;
            end else begin
                v_t = v_ext >>> (sh - SHIFT_WIDTH'(1));
                v_r = (v_t + C_ONE) >>> 1;
            end
            if (v_r > C_QMAX) begin
                v_r   = C_QMAX;
                v_sat = 1'b1;
            end else if (v_r < C_QMIN) begin
                v_r   = C_QMIN;
                v_sat = 1'b1;
            end
        end
        return {v_sat, v_r[DATA_WIDTH-1:0]};
    endfunction

    assign w_s1_adv    = !r_s2_valid || out_ready_i;
    assign acc_ready_o = !r_s1_valid || w_s1_adv;
    assign w_in_acc    = acc_valid_i && acc_ready_o;
    assign w_s2_load   = r_s1_valid && w_s1_adv;

    // Per-lane datapath for both stages plus clip popcount.
    always_comb begin
        w_sum     = '0;
        w_q       = '0;
        w_sat     = '0;
        w_sat_pop = '0;
        for (int k = 0; k < int'(K_CHANNELS); k++) begin
            w_sum[k] = SUM_W'($signed(acc_data_i[k])) + SUM_W'($signed(bias_i[k]));
            {w_sat[k], w_q[k]} = f_quant($signed(r_s1_sum[k]), r_s1_shift, r_s1_relu);
            w_sat_pop = w_sat_pop + POP_W'(w_sat[k]);
        end
        w_sat_sum = {1'b0, r_sat_cnt} + (SAT_CNT_WIDTH + 1)'(w_sat_pop);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_s1_valid <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_relu  <= 1'b0;
            r_s1_shift <= '0;
            r_s1_sum   <= '0;
        end else begin
            if (w_in_acc) begin
                r_s1_sum   <= w_sum;
                r_s1_last  <= acc_last_i;
                r_s1_shift <= shift_i;
                r_s1_relu  <= relu_en_i;
            end
            r_s1_valid <= w_in_acc || (r_s1_valid && !w_s1_adv);
        end
    end

    // Output stage; the counter sticks at all-ones instead of wrapping.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_s2_valid <= 1'b0;
            r_out_last <= 1'b0;
            r_out_data <= '0;
            r_sat_cnt  <= '0;
        end else begin
            if (w_s2_load) begin
                r_out_data <= w_q;
                r_out_last <= r_s1_last;
                r_sat_cnt  <= w_sat_sum[SAT_CNT_WIDTH] ? '1 : w_sat_sum[SAT_CNT_WIDTH-1:0];
            end
            r_s2_valid <= w_s2_load || (r_s2_valid && !out_ready_i);
        end
    end

    assign out_valid_o = r_s2_valid;
    assign out_data_o  = r_out_data;
    assign out_last_o  = r_out_last;
    assign sat_cnt_o   = r_sat_cnt;

endmodule
